// File: rtl/mem_request_unit_if.sv
// Operation type and the execute/data-memory signal bundle of mem_request_unit.
// master: the request unit itself; slave: the pipeline plus data memory.
package mem_request_unit_pkg;

  typedef enum logic [3:0] {
    NOP    = 4'd0,
    LB     = 4'd1,
    LBU    = 4'd2,
    LH     = 4'd3,
    LHU    = 4'd4,
    LW     = 4'd5,
    SB     = 4'd6,
    SH     = 4'd7,
    SW     = 4'd8,
    ALU    = 4'd9,
    BRANCH = 4'd10
  } iType_e;

endpackage

interface mem_request_unit_if;
  import mem_request_unit_pkg::*;

  logic        valid_i;
  iType_e      instruction_operation_i;
  logic [31:0] address_i;
  logic [31:0] store_data_i;
  logic        hold_o;
  logic        mem_req_o;
  logic        mem_gnt_i;
  logic [31:0] mem_address_o;
  logic [3:0]  mem_write_enable_o;
  logic [31:0] mem_data_o;
  logic        done_o;
  logic        bus_error_o;
  logic        misaligned_o;

  modport master (
    input  valid_i,
    input  instruction_operation_i,
    input  address_i,
    input  store_data_i,
    input  mem_gnt_i,
    output hold_o,
    output mem_req_o,
    output mem_address_o,
    output mem_write_enable_o,
    output mem_data_o,
    output done_o,
    output bus_error_o,
    output misaligned_o
  );

  modport slave (
    output valid_i,
    output instruction_operation_i,
    output address_i,
    output store_data_i,
    output mem_gnt_i,
    input  hold_o,
    input  mem_req_o,
    input  mem_address_o,
    input  mem_write_enable_o,
    input  mem_data_o,
    input  done_o,
    input  bus_error_o,
    input  misaligned_o
  );

endinterface

// File: rtl/mem_request_unit.sv
// Load/store request issue: alignment check, lane strobes/replicated data, req/gnt with timeout.
// Optional MISALIGN_TRAP_EN: misaligned ops are flagged and not issued instead of being truncated.
module mem_request_unit
  import mem_request_unit_pkg::*;
#(
  parameter int unsigned GNT_TIMEOUT = 255
) (
  input logic                clk,
  input logic                reset,
  mem_request_unit_if.master bus
);

  localparam int unsigned CntW = (GNT_TIMEOUT > 255) ? $clog2(GNT_TIMEOUT + 1) : 8;

  localparam logic [0:0] StIdle = 1'b0;
  localparam logic [0:0] StReq  = 1'b1;

  logic [0:0]      state_q;
  logic            req_q;
  logic [31:0]     addr_q;
  logic [3:0]      we_q;
  logic [31:0]     data_q;
  logic            done_q;
  logic            berr_q;
  logic [CntW-1:0] cnt_q;

  logic            is_mem;
  logic            is_half;
  logic            is_word;
  logic [3:0]      lane_we;
  logic [31:0]     lane_data;
  logic            misaligned;
  logic            accept;
  logic [CntW-1:0] cnt_inc;
  logic            timeout_hit;
  logic [1:0]      lane_off;

  assign lane_off = bus.address_i[1:0];

  always_comb begin
    is_mem  = 1'b0;
    is_half = 1'b0;
    is_word = 1'b0;
    case (bus.instruction_operation_i)
      LB, LBU, SB: is_mem = 1'b1;
      LH, LHU, SH: begin
        is_mem  = 1'b1;
        is_half = 1'b1;
      end
      LW, SW: begin
        is_mem  = 1'b1;
        is_word = 1'b1;
      end
      default: ;
    endcase
  end

  // Loads leave strobes and data at zero; only stores drive lanes.
  always_comb begin
    lane_we   = 4'b0000;
    lane_data = 32'h0000_0000;
    case (bus.instruction_operation_i)
      SB: begin
        lane_we   = 4'b0001 << lane_off;
        lane_data = {4{bus.store_data_i[7:0]}};
      end
      SH: begin
        lane_we   = lane_off[1] ? 4'b1100 : 4'b0011;
        lane_data = {2{bus.store_data_i[15:0]}};
      end
      SW: begin
        lane_we   = 4'b1111;
        lane_data = bus.store_data_i;
      end
      default: ;
    endcase
  end

`ifdef MISALIGN_TRAP_EN
  logic mis_cond;
  assign mis_cond   = (is_half && lane_off[0]) || (is_word && (lane_off != 2'b00));
  assign misaligned = bus.valid_i && (state_q == StIdle) && is_mem && mis_cond;
`else
  assign misaligned = 1'b0;
`endif

  assign accept = bus.valid_i && (state_q == StIdle) && is_mem && !misaligned;

  // Counter value after this REQ cycle; abort once it reaches the limit.
  assign cnt_inc     = cnt_q + 1'b1;
  assign timeout_hit = (GNT_TIMEOUT != 0) && (cnt_inc == CntW'(GNT_TIMEOUT));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      req_q   <= 1'b0;
      addr_q  <= 32'h0000_0000;
      we_q    <= 4'b0000;
      data_q  <= 32'h0000_0000;
      done_q  <= 1'b0;
      berr_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      done_q <= 1'b0;
      berr_q <= 1'b0;
      case (state_q)
        StIdle: begin
          if (accept) begin
            state_q <= StReq;
            req_q   <= 1'b1;
            addr_q  <= {bus.address_i[31:2], 2'b00};
            we_q    <= lane_we;
            data_q  <= lane_data;
            cnt_q   <= '0;
          end
        end
        StReq: begin
          if (bus.mem_gnt_i) begin
            state_q <= StIdle;
            req_q   <= 1'b0;
            we_q    <= 4'b0000;
            done_q  <= 1'b1;
          end else if (timeout_hit) begin
            state_q <= StIdle;
            req_q   <= 1'b0;
            we_q    <= 4'b0000;
            berr_q  <= 1'b1;
          end else if (GNT_TIMEOUT != 0) begin
            cnt_q <= cnt_inc;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Reset gates the stall so the pipeline is released in the same cycle.
  assign bus.hold_o             = !reset && ((state_q == StReq) || accept);
  assign bus.mem_req_o          = req_q;
  assign bus.mem_address_o      = addr_q;
  assign bus.mem_write_enable_o = we_q;
  assign bus.mem_data_o         = data_q;
  assign bus.done_o             = done_q;
  assign bus.bus_error_o        = berr_q;
  assign bus.misaligned_o       = misaligned;

  a_pulse_excl : assert property (@(posedge clk) disable iff (reset) !(done_q && berr_q));
  a_req_drop   : assert property (@(posedge clk) disable iff (reset) (done_q || berr_q) |-> !req_q);
  a_req_stable : assert property (@(posedge clk) disable iff (reset)
                   (req_q && $past(req_q)) |-> ($stable(addr_q) && $stable(we_q) && $stable(data_q)));

endmodule
